// File: rtl/alu_arbiter_pkg.sv
// Shared op codes, FSM state encoding and op validity helper for the dALU arbiter.
package alu_arbiter_pkg;

  localparam logic [7:0] OpAdd  = 8'h01;
  localparam logic [7:0] OpAdc  = 8'h02;
  localparam logic [7:0] OpSub  = 8'h03;
  localparam logic [7:0] OpSuc  = 8'h04;
  localparam logic [7:0] OpMul8 = 8'h05;
  localparam logic [7:0] OpCmp  = 8'h09;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StCapt = 2'd2,
    StResp = 2'd3
  } state_e;

  // Ops the shared ALU is allowed to see; anything else (DIV8 included) is answered with zeros.
  function automatic logic is_valid_op(input logic [7:0] op);
    case (op)
      OpAdd, OpAdc, OpSub, OpSuc, OpMul8, OpCmp: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signal bundle of the dALU arbiter.
interface alu_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [8*NREQ-1:0]    req_op;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_cf;
  logic [NREQ-1:0]      rsp_valid;
  logic [15:0]          rsp_acc;
  logic                 rsp_c;
  logic                 rsp_z;
  logic                 rsp_o;
  logic                 busy;
  logic [15:0]          alu_a;
  logic [15:0]          alu_b;
  logic [7:0]           alu_op;
  logic                 alu_cf;
  logic [15:0]          alu_acc;
  logic                 alu_c;
  logic                 alu_z;
  logic                 alu_o;

  // Environment side: requesters plus the ALU itself.
  modport master (
    output req_valid, req_op, req_a, req_b, req_cf,
    input  req_ready, rsp_valid, rsp_acc, rsp_c, rsp_z, rsp_o, busy,
    input  alu_a, alu_b, alu_op, alu_cf,
    output alu_acc, alu_c, alu_z, alu_o
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cf,
    output req_ready, rsp_valid, rsp_acc, rsp_c, rsp_z, rsp_o, busy,
    output alu_a, alu_b, alu_op, alu_cf,
    input  alu_acc, alu_c, alu_z, alu_o
  );
endinterface

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin grant: first valid requester at or after the pointer.
module alu_arbiter_rr #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IdxW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IdxW-1:0] gnt_idx
);

  localparam logic [IdxW:0] NreqW = (IdxW + 1)'(NREQ);

  logic [IdxW:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      // Extra bit lets the sum exceed NREQ-1 before the wrap.
      cand = {1'b0, ptr} + (IdxW + 1)'(off);
      if (cand >= NreqW) begin
        cand = cand - NreqW;
      end
      if (!found && valid[cand[IdxW-1:0]]) begin
        found                 = 1'b1;
        gnt_idx               = cand[IdxW-1:0];
        gnt[cand[IdxW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered 16-bit ALU between NREQ requesters, one op in flight, round-robin grant.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic      clk,
  input  logic      rst,
  alu_arbiter_if.slave bus
);

  localparam int unsigned      IdxW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NREQ - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, idx_q, gnt_idx;
  logic [NREQ-1:0]   gnt, rsp_valid_q;
  logic              accept;

  logic [7:0]        op_q, sel_op, alu_op_q;
  logic [15:0]       sel_a, sel_b, alu_a_q, alu_b_q;
  logic              sel_cf, alu_cf_q;

  logic [15:0]       cap_acc, rsp_acc_q;
  logic              cap_c, cap_z, cap_o, rsp_c_q, rsp_z_q, rsp_o_q;

  alu_arbiter_rr #(
    .NREQ(NREQ)
  ) u_rr (
    .valid   (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_op = bus.req_op[{gnt_idx, 3'b000} +: 8];
  assign sel_a  = bus.req_a[{gnt_idx, 4'b0000} +: 16];
  assign sel_b  = bus.req_b[{gnt_idx, 4'b0000} +: 16];
  assign sel_cf = bus.req_cf[gnt_idx];

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = '0;
    case (state_q)
      StIdle: begin
        bus.req_ready = rst ? '0 : gnt;
        accept        = |gnt;
        if (accept) begin
          state_d = StExec;
        end
      end
      StExec:  state_d = StCapt;
      StCapt:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // MUL8 leaves c/o stale and CMP leaves acc stale in the ALU, so those are masked here.
  always_comb begin
    cap_acc = bus.alu_acc;
    cap_c   = bus.alu_c;
    cap_z   = bus.alu_z;
    cap_o   = bus.alu_o;
    if (!is_valid_op(op_q)) begin
      cap_acc = '0;
      cap_c   = 1'b0;
      cap_z   = 1'b0;
      cap_o   = 1'b0;
    end else if (op_q == OpMul8) begin
      cap_c   = 1'b0;
      cap_o   = 1'b0;
    end else if (op_q == OpCmp) begin
      cap_acc = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      idx_q       <= '0;
      op_q        <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cf_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_acc_q   <= '0;
      rsp_c_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
      rsp_o_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            idx_q    <= gnt_idx;
            op_q     <= sel_op;
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
            alu_cf_q <= sel_cf;
            alu_op_q <= is_valid_op(sel_op) ? sel_op : 8'h00;
          end
        end
        StCapt: begin
          rsp_acc_q   <= cap_acc;
          rsp_c_q     <= cap_c;
          rsp_z_q     <= cap_z;
          rsp_o_q     <= cap_o;
          rsp_valid_q <= NREQ'(1) << idx_q;
        end
        StResp: begin
          ptr_q <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_cf    = alu_cf_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_acc   = rsp_acc_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_o     = rsp_o_q;

endmodule
